mem_port_responder: RTL
=======================

Name: mem_port_responder

Overview:
- Memory-side responder for the multicycle TSC CPU control path.
- Accepts the read strobe (fetch or LWD) and write strobe (SWD) issued by the control unit and runs a fixed-latency access on an external synchronous memory.
- Returns read data and a one-cycle completion pulse; the control unit holds its state until that pulse arrives.
- Sits between the datapath address/data mux (IorD output) and the memory model.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- LATENCY, 2, memory access cycles per request; legal range 1..15.
- CNT_W, 4, width of the wait-state counter; must hold LATENCY-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_read  input  1  read request (fetch or LWD), level, held by the CPU until o_ready.
- i_write  input  1  write request (SWD), level, held by the CPU until o_ready.
- i_addr  input  WORD_SIZE  request address.
- i_wdata  input  WORD_SIZE  write data.
- o_rdata  output  WORD_SIZE  read data; valid while o_ready is high and held afterwards.
- o_ready  output  1  one-cycle completion pulse.
- o_busy  output  1  high whenever state is not IDLE.
- mem_addr  output  WORD_SIZE  memory address, registered.
- mem_read  output  1  memory read strobe, registered.
- mem_write  output  1  memory write strobe, registered.
- mem_wdata  output  WORD_SIZE  memory write data, registered.
- mem_rdata  input  WORD_SIZE  memory read data; valid on the final access cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; all outputs 0, including o_rdata, mem_* and the counter.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On the rising edge with i_write=1: latch i_addr and i_wdata into mem_addr and mem_wdata, set mem_write=1, cnt=LATENCY-1, go to ACCESS.
  - Else with i_read=1: same, but set mem_read=1.
  - i_read and i_write both high: write wins; the read is dropped and gets no response.
- ACCESS:
  - Strobes, mem_addr and mem_wdata are held stable.
  - Inputs are ignored; changes to i_addr or i_wdata have no effect.
  - cnt≠0: decrement cnt.
  - cnt==0 at the edge: if a read, capture mem_rdata into o_rdata; clear the strobes; go to RESP.
- RESP: o_ready=1 for exactly one cycle, then go to IDLE.
- Timing, with the request edge as cycle 0: strobes high in cycles 1..LATENCY; o_ready high in cycle LATENCY+1. For LATENCY=2, o_ready is high in cycle 3.
- Write responses: o_rdata is unchanged.
- Back-to-back requests: the CPU drops its request in the o_ready cycle.
  - A request still high in the following IDLE cycle starts a new access. Minimum spacing is LATENCY+2 cycles per request.
- reset_n low mid-ACCESS: strobes drop asynchronously, the pending request is discarded and no o_ready is issued. After release, the block is in IDLE.
- LATENCY=1: cnt is 0 on entry, so ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: MEM_RBUF_EN.
- Defined: adds a single-entry read buffer holding the last read address, its data and a valid bit.
  - Read hit in IDLE (valid and i_addr equals the tag): skip ACCESS and go directly to RESP, with o_rdata loaded from the buffer at the same edge.
    - No mem strobe is issued.
    - o_ready is high in cycle 1.
  - Every completed memory read fills the buffer.
  - A write to the tagged address updates the buffer data.
  - Reset clears the valid bit.
- Undefined: no buffer; every read takes the full LATENCY path.

Test Plan:
- Reset, then read addr 0x0010 with mem_rdata=0xBEEF, LATENCY=2:
  - mem_read high in cycles 1-2 with mem_addr=0x0010.
  - o_ready high in cycle 3 only; o_rdata=0xBEEF.
- Write addr 0x0020, data 0x1234: mem_write high in cycles 1-2 with mem_wdata=0x1234; o_ready in cycle 3; o_rdata unchanged.
- i_read and i_write both high at addr 0x0030: only mem_write is asserted; exactly one o_ready is issued.
- Request held through o_ready: a second access starts in cycle 4 and its o_ready arrives in cycle 7. i_addr toggled during ACCESS leaves mem_addr stable.
- reset_n pulsed low in cycle 2 of a read: mem_read drops immediately; no o_ready; o_busy=0 after release.
- With MEM_RBUF_EN: read 0x0040 (=0x5555) twice.
  - Second read: o_ready in cycle 1 with no mem_read.
  - Then write 0x0040=0xAAAA and read it again: returns 0xAAAA from the buffer.

Source files
------------

// File: rtl/mem_port_responder.sv
// mem_port_responder
//
// Memory-side responder for the multicycle TSC CPU control path. The control
// unit raises a level read (fetch / LWD) or write (SWD) request and holds it;
// this block runs a fixed-latency access on an external synchronous memory
// and answers with a one-cycle o_ready pulse (plus read data for reads).
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   i_read     read request, held by the CPU until o_ready
//   i_write    write request, held by the CPU until o_ready (wins over i_read)
//   i_addr     request address
//   i_wdata    write data
//   o_rdata    read data, valid with o_ready and held afterwards
//   o_ready    one-cycle completion pulse
//   o_busy     high whenever the FSM is not IDLE
//   mem_addr   registered memory address
//   mem_read   registered memory read strobe
//   mem_write  registered memory write strobe
//   mem_wdata  registered memory write data
//   mem_rdata  memory read data, valid on the final access cycle
//
// Optional feature (macro MEM_RBUF_EN): a single-entry read buffer holding the
// last read address, its data and a valid bit. A read hit answers directly
// from the buffer with o_ready in the cycle after the request edge and no
// memory strobe. Without the macro every read takes the full LATENCY path.

module mem_port_responder #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 2,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_read,
  input  logic                 i_write,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] o_rdata,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 ready_q;
  logic [WORD_SIZE-1:0] memAddr_q;
  logic [WORD_SIZE-1:0] memWdata_q;
  logic                 memRead_q;
  logic                 memWrite_q;
  logic                 bufHit;
  logic [WORD_SIZE-1:0] bufRdata;
  logic                 accessDone;

  // The last access cycle is the one where the wait counter has run out.
  assign accessDone = (state_q == ACCESS) && (cnt_q == '0);

`ifdef MEM_RBUF_EN
  logic                 bufValid_q;
  logic [WORD_SIZE-1:0] bufTag_q;
  logic [WORD_SIZE-1:0] bufData_q;

  assign bufHit   = bufValid_q && (i_addr == bufTag_q);
  assign bufRdata = bufData_q;

  // Completed memory reads refill the buffer; a completed write to the tagged
  // address keeps the buffered copy coherent with memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bufValid_q <= 1'b0;
      bufTag_q   <= '0;
      bufData_q  <= '0;
    end else if (accessDone) begin
      if (memRead_q) begin
        bufValid_q <= 1'b1;
        bufTag_q   <= memAddr_q;
        bufData_q  <= mem_rdata;
      end else if (memWrite_q && bufValid_q && (memAddr_q == bufTag_q)) begin
        bufData_q  <= memWdata_q;
      end
    end
  end
`else
  assign bufHit   = 1'b0;
  assign bufRdata = '0;
`endif

  // Main FSM. All outputs are registered here, so the asynchronous reset drops
  // the memory strobes immediately and discards any pending access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_write) begin
            memAddr_q  <= i_addr;
            memWdata_q <= i_wdata;
            memWrite_q <= 1'b1;
            cnt_q      <= CNT_LOAD;
            state_q    <= ACCESS;
          end else if (i_read && bufHit) begin
            rdata_q <= bufRdata;
            ready_q <= 1'b1;
            state_q <= RESP;
          end else if (i_read) begin
            memAddr_q  <= i_addr;
            memWdata_q <= i_wdata;
            memRead_q  <= 1'b1;
            cnt_q      <= CNT_LOAD;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            if (memRead_q) begin
              rdata_q <= mem_rdata;
            end
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_rdata   = rdata_q;
  assign o_ready   = ready_q;
  assign o_busy    = (state_q != IDLE);
  assign mem_addr  = memAddr_q;
  assign mem_read  = memRead_q;
  assign mem_write = memWrite_q;
  assign mem_wdata = memWdata_q;

endmodule
